// File: rtl/bi_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Optional macro BI_BCD_SIGNED_EN: two's-complement input, magnitude + sign_out.
module bi_bcd_seq #(
  parameter int BIN_W  = 32,  // binary input width, at least 4
  parameter int DIGITS = 10   // BCD digits, 10**DIGITS must exceed 2**BIN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BI_BCD_SIGNED_EN
  ,
  output logic                  sign_out
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int CNT_W = $clog2(BIN_W);

  logic [0:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [BIN_W-1:0]    bin_q;
  logic [BIN_W-1:0]    magnitude;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_step;

`ifdef BI_BCD_SIGNED_EN
  logic neg_q;
  // Negating -2**(BIN_W-1) yields 2**(BIN_W-1) read as unsigned, which is exact.
  assign magnitude = binary_in[BIN_W-1] ? ('0 - binary_in) : binary_in;
`else
  assign magnitude = binary_in;
`endif

  // NOTE: bcd_adj gets a full default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift the whole {bcd, bin} pair left by one: binary MSB enters BCD digit 0.
  assign bcd_step = {bcd_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};

  assign busy = (state == SHIFT);

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      bcd_out  <= '0;
      done     <= 1'b0;
`ifdef BI_BCD_SIGNED_EN
      neg_q    <= 1'b0;
      sign_out <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          bin_q <= magnitude;
          bcd_q <= '0;
          cnt   <= '0;
          state <= SHIFT;
`ifdef BI_BCD_SIGNED_EN
          neg_q <= binary_in[BIN_W-1];
`endif
        end
      end else begin
        bin_q <= bin_q << 1;
        bcd_q <= bcd_step;
        cnt   <= cnt + CNT_W'(1);
        // The last step publishes directly, so bcd_out never shows partial digits.
        if (cnt == CNT_W'(BIN_W - 1)) begin
          state    <= IDLE;
          done     <= 1'b1;
          bcd_out  <= bcd_step;
`ifdef BI_BCD_SIGNED_EN
          sign_out <= neg_q;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_bi_bcd_seq.sv
// Self-checking bench for bi_bcd_seq (BIN_W=32, DIGITS=10): directed table plus
// back-to-back, ignored-start and mid-conversion reset sequences.
module tb_bi_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] binary_in;
  logic        busy;
  logic        done;
  logic [39:0] bcd_out;
`ifdef BI_BCD_SIGNED_EN
  logic        sign_out;
`endif

  always #5 clk = ~clk;

  bi_bcd_seq #(.BIN_W(32), .DIGITS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .binary_in (binary_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out)
`ifdef BI_BCD_SIGNED_EN
    ,
    .sign_out  (sign_out)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] value;
    logic [39:0] bcd;
    logic        sgn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] v, input logic [39:0] b, input logic s);
    vec_t r;
    r.value = v;
    r.bcd   = b;
    r.sgn   = s;
    return r;
  endfunction

  // Drive a request; returns #1 after the accepting edge T.
  task automatic start_conv(input logic [31:0] v);
    binary_in = v;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns #1 after the edge that raised done (or on timeout).
  task automatic wait_done(input int inject_at, output int cyc, output bit busy_ok,
                           output bit hold_ok, output bit timed_out);
    logic [39:0] held;
    bit fin;
    held      = bcd_out;
    cyc       = 0;
    busy_ok   = (busy === 1'b1);
    hold_ok   = 1'b1;
    timed_out = 1'b0;
    fin       = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == inject_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_ok = 1'b0;
        fin = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (bcd_out !== held) hold_ok = 1'b0;
        if (cyc == inject_at) begin
          binary_in = 32'd63;
          start     = 1'b1;
        end
        if (cyc >= 100) begin
          timed_out = 1'b1;
          fin       = 1'b1;
        end
      end
    end
  endtask

  task automatic finish_checks(input string name, input int cyc, input bit busy_ok,
                               input bit hold_ok, input bit timed_out,
                               input logic [39:0] exp_bcd, input logic exp_sgn);
    check({name, " timeout"}, 64'(timed_out), 64'd0);
    check({name, " latency"}, 64'(cyc), 64'd32);
    check({name, " bcd_out"}, 64'(bcd_out), 64'(exp_bcd));
    check({name, " busy_profile"}, 64'(busy_ok), 64'd1);
    check({name, " bcd_hold"}, 64'(hold_ok), 64'd1);
`ifdef BI_BCD_SIGNED_EN
    check({name, " sign_out"}, 64'(sign_out), 64'(exp_sgn));
`else
    if (exp_sgn !== 1'b0) check({name, " unsigned_table"}, 64'(exp_sgn), 64'd0);
`endif
  endtask

  task automatic run_vec(input string name, input logic [31:0] v,
                         input logic [39:0] exp_bcd, input logic exp_sgn);
    int cyc;
    bit busy_ok, hold_ok, timed_out;
    start_conv(v);
    wait_done(-10, cyc, busy_ok, hold_ok, timed_out);
    finish_checks(name, cyc, busy_ok, hold_ok, timed_out, exp_bcd, exp_sgn);
  endtask

  // Counts done pulses over n cycles.
  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int  cyc;
    int  extra;
    bit  busy_ok, hold_ok, timed_out;

    vecs.push_back(mk(32'd0,          40'h00_0000_0000, 1'b0));
    vecs.push_back(mk(32'd1,          40'h00_0000_0001, 1'b0));
    vecs.push_back(mk(32'd9,          40'h00_0000_0009, 1'b0));
    vecs.push_back(mk(32'd10,         40'h00_0000_0010, 1'b0));
    vecs.push_back(mk(32'd15,         40'h00_0000_0015, 1'b0));
    vecs.push_back(mk(32'd99,         40'h00_0000_0099, 1'b0));
    vecs.push_back(mk(32'd100,        40'h00_0000_0100, 1'b0));
    vecs.push_back(mk(32'd12345678,   40'h00_1234_5678, 1'b0));
    vecs.push_back(mk(32'd99999999,   40'h00_9999_9999, 1'b0));
    vecs.push_back(mk(32'd1000000000, 40'h10_0000_0000, 1'b0));
`ifdef BI_BCD_SIGNED_EN
    vecs.push_back(mk(32'hFFFF_FFF1,  40'h00_0000_0015, 1'b1));
    vecs.push_back(mk(32'h8000_0000,  40'h21_4748_3648, 1'b1));
    vecs.push_back(mk(32'hFFFF_FFFF,  40'h00_0000_0001, 1'b1));
    vecs.push_back(mk(32'h7FFF_FFFF,  40'h21_4748_3647, 1'b0));
`else
    vecs.push_back(mk(32'h8000_0000,  40'h21_4748_3648, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF,  40'h42_9496_7295, 1'b0));
`endif

    rst_n     = 1'b0;
    start     = 1'b0;
    binary_in = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset bcd_out", 64'(bcd_out), 64'd0);
`ifdef BI_BCD_SIGNED_EN
    check("reset sign_out", 64'(sign_out), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      run_vec($sformatf("vec%0d", i), vecs[i].value, vecs[i].bcd, vecs[i].sgn);
    end

    // Back-to-back: second request issued in the done cycle of the first.
    @(negedge clk);
    start_conv(32'd127);
    wait_done(-10, cyc, busy_ok, hold_ok, timed_out);
    finish_checks("b2b_first", cyc, busy_ok, hold_ok, timed_out, 40'h00_0000_0127, 1'b0);
    start_conv(32'hFFFF_FFFF);
    check("b2b accepted busy", 64'(busy), 64'd1);
    check("b2b done dropped", 64'(done), 64'd0);
    wait_done(-10, cyc, busy_ok, hold_ok, timed_out);
`ifdef BI_BCD_SIGNED_EN
    finish_checks("b2b_second", cyc, busy_ok, hold_ok, timed_out, 40'h00_0000_0001, 1'b1);
`else
    finish_checks("b2b_second", cyc, busy_ok, hold_ok, timed_out, 40'h42_9496_7295, 1'b0);
`endif

    // Start while busy (and binary_in changed after capture) is ignored.
    @(negedge clk);
    start_conv(32'd31);
    wait_done(10, cyc, busy_ok, hold_ok, timed_out);
    finish_checks("ignored_start", cyc, busy_ok, hold_ok, timed_out, 40'h00_0000_0031, 1'b0);
    count_dones(40, extra);
    check("ignored_start extra done", 64'(extra), 64'd0);
    check("ignored_start idle", 64'(busy), 64'd0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start_conv(32'd99999);
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset bcd_out", 64'(bcd_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, extra);
    check("midreset no done", 64'(extra), 64'd0);
    check("midreset stays idle", 64'(busy), 64'd0);
    @(negedge clk);
    run_vec("post_reset_zero", 32'd0, 40'h00_0000_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
